// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the filter sequencing controller.
// The optional dropped-sample counter is enabled with FILTER_CTRL_DROPCNT_EN.
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int FLUSH_CYCLES = 2;
  localparam int DEFAULT_W    = 8;

endpackage

// File: rtl/filter_ctrl_fifo.sv
// Sample FIFO with registered head/valid outputs; a push into an empty FIFO
// becomes visible one cycle later, a pop of the last entry drops valid at once.
module filter_ctrl_fifo
  import filter_ctrl_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         dvalid,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push_ok;
  logic          pop_ok;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pop_ok     = pop && !empty;
  assign push_ok    = push && (!full || pop_ok);
  assign rd_next    = rd_ptr + AW'(pop_ok);
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      count  <= count_next;
      dvalid <= (count_next != '0) && !empty;
      // The slot being written this edge may become the new head: bypass it.
      if (count_next != '0)
        dout <= (push_ok && (wr_ptr == rd_next)) ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/filter_ctrl.sv
// Filter sequencing controller: clear pulse, decimation strobe, settle discard,
// sample FIFO with sticky overflow. FILTER_CTRL_DROPCNT_EN adds DROP_CNT.
module filter_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int DECIM  = 64,
  parameter int SETTLE = 2,
  parameter int DEPTH  = 4,
  parameter int W      = DEFAULT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] FILT_OUT,
  output logic         FILT_CLR,
  output logic [W-1:0] DOUT,
  output logic         DVALID,
  input  logic         DREADY,
  output logic         OVF,
  input  logic         CLR_OVF,
  output state_t       DBG_STATE
`ifdef FILTER_CTRL_DROPCNT_EN
  ,
  output logic [7:0]   DROP_CNT
`endif
);

  localparam int DW = $clog2(DECIM);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [DW-1:0] DECIM_LAST  = DW'(DECIM - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] dcnt;
  logic [SW-1:0] settle_cnt;
  logic [FW-1:0] flush_cnt;
  logic          counting;
  logic          strobe;
  logic          push;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;

  assign DBG_STATE = state;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= filter_ctrl_pkg::IDLE;
    else     state <= state_next;
  end

  // Next-state logic; dropping EN aborts from any active state
  always_comb begin
    state_next = state;
    case (state)
      filter_ctrl_pkg::IDLE:
        if (EN) state_next = filter_ctrl_pkg::FLUSH;
      filter_ctrl_pkg::FLUSH:
        if (!EN) state_next = filter_ctrl_pkg::IDLE;
        else if (flush_cnt == FLUSH_LAST)
          state_next = (SETTLE == 0) ? filter_ctrl_pkg::RUN : filter_ctrl_pkg::SETTLE;
      filter_ctrl_pkg::SETTLE:
        if (!EN) state_next = filter_ctrl_pkg::IDLE;
        else if (strobe && (settle_cnt == SETTLE_LAST)) state_next = filter_ctrl_pkg::RUN;
      filter_ctrl_pkg::RUN:
        if (!EN) state_next = filter_ctrl_pkg::IDLE;
      default:
        state_next = filter_ctrl_pkg::IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    counting = (state == filter_ctrl_pkg::SETTLE) || (state == filter_ctrl_pkg::RUN);
    strobe   = counting && (dcnt == DECIM_LAST);
    push     = (state == filter_ctrl_pkg::RUN) && strobe;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dcnt       <= '0;
      settle_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!EN || !counting || strobe) dcnt <= '0;
      else                            dcnt <= dcnt + DW'(1);
      if ((state == filter_ctrl_pkg::FLUSH) && EN) flush_cnt <= flush_cnt + FW'(1);
      else                                         flush_cnt <= '0;
      if (state != filter_ctrl_pkg::SETTLE) settle_cnt <= '0;
      else if (strobe)                      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  // Clear lags FLUSH by one edge so it is high after exactly the two following edges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) FILT_CLR <= 1'b0;
    else     FILT_CLR <= (state == filter_ctrl_pkg::FLUSH);
  end

  assign pop  = DVALID && DREADY && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  // A new overflow beats a same-cycle clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          OVF <= 1'b0;
    else if (drop)    OVF <= 1'b1;
    else if (CLR_OVF) OVF <= 1'b0;
  end

`ifdef FILTER_CTRL_DROPCNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) DROP_CNT <= 8'd0;
    else if (drop) begin
      if (CLR_OVF)                DROP_CNT <= 8'd1;
      else if (DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
    end else if (CLR_OVF) DROP_CNT <= 8'd0;
  end
`endif

  filter_ctrl_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .push   (push),
    .din    (FILT_OUT),
    .pop    (pop),
    .dout   (DOUT),
    .dvalid (DVALID),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_filter_ctrl.sv
// Directed bench for filter_ctrl (DECIM=4, SETTLE=1, DEPTH=4) with a sample
// scoreboard; also checks DROP_CNT when FILTER_CTRL_DROPCNT_EN is defined.
module tb_filter_ctrl;
  import filter_ctrl_pkg::*;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic [W-1:0] FILT_OUT = '0;
  logic         FILT_CLR;
  logic [W-1:0] DOUT;
  logic         DVALID;
  logic         DREADY = 1'b0;
  logic         OVF;
  logic         CLR_OVF = 1'b0;
  state_t       DBG_STATE;
`ifdef FILTER_CTRL_DROPCNT_EN
  logic [7:0]   DROP_CNT;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard and timing model state
  logic [W-1:0] exp_q[$];
  logic         exp_ovf = 1'b0;
  int           exp_drop = 0;
  bit           mon_on = 1'b0;
  bit           m_active = 1'b0;
  int           m_n = 0;

  filter_ctrl #(
    .DECIM  (4),
    .SETTLE (1),
    .DEPTH  (4),
    .W      (W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .FILT_OUT  (FILT_OUT),
    .FILT_CLR  (FILT_CLR),
    .DOUT      (DOUT),
    .DVALID    (DVALID),
    .DREADY    (DREADY),
    .OVF       (OVF),
    .CLR_OVF   (CLR_OVF),
    .DBG_STATE (DBG_STATE)
`ifdef FILTER_CTRL_DROPCNT_EN
    ,
    .DROP_CNT  (DROP_CNT)
`endif
  );

  // Clock and per-cycle incrementing filter output
  always #5 CLK = ~CLK;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      FILT_OUT = FILT_OUT + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: on each falling edge, check the state left by the last rising
  // edge, then predict what the coming rising edge will do.
  always @(negedge CLK) begin
    logic pop;
    logic push;
    logic drop;
    int   nn;
    if (RST) begin
      exp_q.delete();
      exp_ovf  = 1'b0;
      exp_drop = 0;
      m_active = 1'b0;
      m_n      = 0;
    end else if (mon_on) begin
      check("filt_clr", {31'd0, FILT_CLR}, {31'd0, m_active && (m_n == 1 || m_n == 2)});
      check("ovf", {31'd0, OVF}, {31'd0, exp_ovf});
`ifdef FILTER_CTRL_DROPCNT_EN
      check("drop_cnt", {24'd0, DROP_CNT}, exp_drop);
`endif
      pop = DVALID && DREADY;
      drop = 1'b0;
      if (pop) begin
        if (exp_q.size() == 0) begin
          check("pop_empty", {31'd0, DVALID}, 32'd0);
        end else begin
          check("pop_dout", {24'd0, DOUT}, {24'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
      push = 1'b0;
      nn = m_n + 1;
      if (m_active && nn >= 10 && ((nn - 10) % 4) == 0) push = 1'b1;
      if (push) begin
        if (exp_q.size() == 4) drop = 1'b1;
        else exp_q.push_back(FILT_OUT);
      end
      if (drop) begin
        exp_ovf  = 1'b1;
        exp_drop = CLR_OVF ? 1 : ((exp_drop == 255) ? 255 : exp_drop + 1);
      end else if (CLR_OVF) begin
        exp_ovf  = 1'b0;
        exp_drop = 0;
      end
      if (m_active) begin
        m_n = nn;
        if (!EN) m_active = 1'b0;
      end else if (EN) begin
        m_active = 1'b1;
        m_n      = 0;
      end
    end
  end

  initial begin
    int first;
    // Reset state
    tick(3);
    check("rst_dvalid", {31'd0, DVALID}, 32'd0);
    check("rst_dout", {24'd0, DOUT}, 32'd0);
    check("rst_ovf", {31'd0, OVF}, 32'd0);
    check("rst_clr", {31'd0, FILT_CLR}, 32'd0);
    check("rst_state", {30'd0, DBG_STATE}, {30'd0, IDLE});
`ifdef FILTER_CTRL_DROPCNT_EN
    check("rst_drop_cnt", {24'd0, DROP_CNT}, 32'd0);
`endif
    RST = 1'b0;
    mon_on = 1'b1;
    tick(2);

    // Startup: first sample visible after edge 11, then one per 4 cycles
    EN = 1'b1;
    DREADY = 1'b1;
    first = -1;
    for (int e = 0; e <= 20; e++) begin
      tick(1);
      if (DVALID && first < 0) first = e;
    end
    check("first_dvalid_edge", first, 32'd11);
    check("drained_a", exp_q.size(), 32'd0);

    // Backpressure: strobes 22,26,30,34 fill the FIFO, 38 overflows
    DREADY = 1'b0;
    tick(18);
    check("ovf_set", {31'd0, OVF}, 32'd1);
`ifdef FILTER_CTRL_DROPCNT_EN
    check("drop_cnt_one", {24'd0, DROP_CNT}, 32'd1);
`endif

    // Clear racing a new overflow on edge 42, then a clean clear on edge 43
    tick(3);
    CLR_OVF = 1'b1;
    tick(1);
    check("ovf_race", {31'd0, OVF}, 32'd1);
    tick(1);
    check("ovf_cleared", {31'd0, OVF}, 32'd0);
    CLR_OVF = 1'b0;

    // Full FIFO with a pop on strobe edge 46: no overflow, still full after
    tick(2);
    DREADY = 1'b1;
    tick(1);
    DREADY = 1'b0;
    check("full_pop_ovf", {31'd0, OVF}, 32'd0);
    check("full_pop_dvalid", {31'd0, DVALID}, 32'd1);
    tick(4);
    check("still_full", {31'd0, OVF}, 32'd1);
    CLR_OVF = 1'b1;
    tick(1);
    CLR_OVF = 1'b0;
    check("ovf_clear2", {31'd0, OVF}, 32'd0);

    // Stop from RUN, then restart and abort mid-SETTLE
    EN = 1'b0;
    tick(1);
    check("stop_run", {30'd0, DBG_STATE}, {30'd0, IDLE});
    tick(2);
    EN = 1'b1;
    tick(1);
    check("restart_flush", {30'd0, DBG_STATE}, {30'd0, FLUSH});
    tick(4);
    check("restart_settle", {30'd0, DBG_STATE}, {30'd0, SETTLE});
    EN = 1'b0;
    tick(1);
    check("stop_settle", {30'd0, DBG_STATE}, {30'd0, IDLE});
    check("fifo_intact", {31'd0, DVALID}, 32'd1);
    tick(3);

    // Full restart: same timing, FIFO drains first
    EN = 1'b1;
    DREADY = 1'b1;
    first = -1;
    for (int e = 0; e <= 14; e++) begin
      tick(1);
      if (e == 1) check("seq_flush", {30'd0, DBG_STATE}, {30'd0, FLUSH});
      if (e == 2) check("seq_settle", {30'd0, DBG_STATE}, {30'd0, SETTLE});
      if (e == 5) check("drained_b", exp_q.size(), 32'd0);
      if (e == 6) check("seq_run", {30'd0, DBG_STATE}, {30'd0, RUN});
      if (e >= 5 && DVALID && first < 0) begin
        first = e;
        DREADY = 1'b0;
      end
    end
    check("restart_dvalid_edge", first, 32'd11);

    // Async reset mid-RUN with three entries held
    tick(5);
    check("pre_rst_dvalid", {31'd0, DVALID}, 32'd1);
    #2;
    RST = 1'b1;
    EN = 1'b0;
    #1;
    check("arst_dvalid", {31'd0, DVALID}, 32'd0);
    check("arst_ovf", {31'd0, OVF}, 32'd0);
    check("arst_clr", {31'd0, FILT_CLR}, 32'd0);
    check("arst_dout", {24'd0, DOUT}, 32'd0);
    check("arst_state", {30'd0, DBG_STATE}, {30'd0, IDLE});
    tick(2);
    RST = 1'b0;
    tick(3);
    check("post_rst_dvalid", {31'd0, DVALID}, 32'd0);
    check("post_rst_state", {30'd0, DBG_STATE}, {30'd0, IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
